// File: rtl/alu_driver_if.sv
// rtl/alu_driver_if.sv - command and ALU-facing signal bundle for alu_driver
interface alu_driver_if;
    logic       start;
    logic [1:0] cmd;
    logic       flag_en;
    logic [7:0] operand;
    logic       busy;
    logic       done;
    logic [7:0] acc;
    logic       carry;
    logic       alu_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic       alu_flagen;
    logic [8:0] alu_res;

    modport slave (
        input  start, cmd, flag_en, operand, alu_res,
        output busy, done, acc, carry, alu_op, alu_a, alu_b, alu_flagen
    );

    modport master (
        output start, cmd, flag_en, operand, alu_res,
        input  busy, done, acc, carry, alu_op, alu_a, alu_b, alu_flagen
    );
endinterface

// File: rtl/alu_driver.sv
// rtl/alu_driver.sv - sequencer holding ALU inputs for a settle window, then capturing acc/carry
module alu_driver #(
    parameter int SETTLE_CYCLES = 3,
    parameter int CNT_W         = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_driver_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [1:0] CMD_ADD  = 2'b00;
    localparam logic [1:0] CMD_SUB  = 2'b01;
    localparam logic [1:0] CMD_LOAD = 2'b10;
    localparam logic [1:0] CMD_CLRC = 2'b11;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       acc_q, acc_d;
    logic             carry_q, carry_d;
    logic             alu_op_q, alu_op_d;
    logic [7:0]       alu_a_q, alu_a_d;
    logic [7:0]       alu_b_q, alu_b_d;
    logic             alu_flagen_q, alu_flagen_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            acc_q        <= '0;
            carry_q      <= 1'b0;
            alu_op_q     <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_flagen_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            carry_q      <= carry_d;
            alu_op_q     <= alu_op_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_flagen_q <= alu_flagen_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        carry_d      = carry_q;
        alu_op_d     = alu_op_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_flagen_d = alu_flagen_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (bus.start) begin
                    case (bus.cmd)
                        CMD_ADD, CMD_SUB: begin
                            alu_a_d      = acc_q;
                            alu_b_d      = bus.operand;
                            alu_op_d     = bus.cmd[0];
                            alu_flagen_d = bus.flag_en;
                            cnt_d        = CNT_LOAD;
                            state_d      = ST_SETTLE;
                        end
                        CMD_LOAD: begin
                            acc_d   = bus.operand;
                            state_d = ST_DONE;
                        end
                        CMD_CLRC: begin
                            carry_d = 1'b0;
                            state_d = ST_DONE;
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
            ST_SETTLE: begin
                // ALU ports stay untouched here; start is deliberately not looked at.
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    acc_d = bus.alu_res[7:0];
                    if (alu_flagen_q) begin
                        carry_d = bus.alu_res[8];
                    end
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.busy       = (state_q == ST_SETTLE);
    assign bus.done       = (state_q == ST_DONE);
    assign bus.acc        = acc_q;
    assign bus.carry      = carry_q;
    assign bus.alu_op     = alu_op_q;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_flagen = alu_flagen_q;
endmodule

// File: tb/tb_alu_driver.sv
// tb/tb_alu_driver.sv - directed vector bench for alu_driver with a behavioural 8-bit add/sub ALU
module tb_alu_driver;
    localparam int SETTLE = 3;

    logic clk;
    logic rst_n;
    alu_driver_if bus();

    alu_driver #(.SETTLE_CYCLES(SETTLE), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference ALU: 9-bit add, or 9-bit subtract whose bit 8 is the borrow.
    assign bus.alu_res = bus.alu_op ? ({1'b0, bus.alu_a} - {1'b0, bus.alu_b})
                                    : ({1'b0, bus.alu_a} + {1'b0, bus.alu_b});

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int overlap = 0;

    always @(negedge clk) if (bus.busy && bus.done) overlap++;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic run_cmd(input logic [1:0] c, input logic f, input logic [7:0] op,
                           input logic [7:0] exp_a,
                           output logic [7:0] got_acc, output logic got_carry,
                           output int lat, output int busy_n, output logic ports_ok);
        busy_n   = 0;
        lat      = 0;
        ports_ok = 1'b1;
        @(negedge clk);
        bus.start = 1'b1; bus.cmd = c; bus.flag_en = f; bus.operand = op;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = n;
                break;
            end
            if (bus.busy) begin
                busy_n++;
                if (bus.alu_a !== exp_a || bus.alu_b !== op ||
                    bus.alu_op !== c[0] || bus.alu_flagen !== f)
                    ports_ok = 1'b0;
            end
        end
        got_acc   = bus.acc;
        got_carry = bus.carry;
    endtask

    typedef struct {
        logic [1:0] cmd;
        logic       flag;
        logic [7:0] op;
        logic [7:0] exp_acc;
        logic       exp_carry;
        int         exp_busy;
    } vec_t;

    vec_t vecs[11];

    logic [7:0] g_acc;
    logic       g_carry;
    int         g_lat, g_busy;
    logic       g_ok;
    logic [7:0] prev_acc;
    int         dones;
    logic       stable_ok;

    initial begin
        vecs[0]  = '{2'b10, 1'b0, 8'h10, 8'h10, 1'b0, 0};
        vecs[1]  = '{2'b00, 1'b1, 8'h05, 8'h15, 1'b0, SETTLE};
        vecs[2]  = '{2'b10, 1'b0, 8'hF0, 8'hF0, 1'b0, 0};
        vecs[3]  = '{2'b00, 1'b1, 8'h20, 8'h10, 1'b1, SETTLE};
        vecs[4]  = '{2'b00, 1'b0, 8'h20, 8'h30, 1'b1, SETTLE};
        vecs[5]  = '{2'b10, 1'b0, 8'h03, 8'h03, 1'b1, 0};
        vecs[6]  = '{2'b01, 1'b1, 8'h05, 8'hFE, 1'b1, SETTLE};
        vecs[7]  = '{2'b11, 1'b0, 8'h00, 8'hFE, 1'b0, 0};
        vecs[8]  = '{2'b01, 1'b1, 8'h01, 8'hFD, 1'b0, SETTLE};
        vecs[9]  = '{2'b00, 1'b1, 8'h03, 8'h00, 1'b1, SETTLE};
        vecs[10] = '{2'b01, 1'b1, 8'h00, 8'h00, 1'b0, SETTLE};

        rst_n = 1'b0;
        bus.start = 1'b0; bus.cmd = 2'b00; bus.flag_en = 1'b0; bus.operand = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_done", {31'd0, bus.done}, 32'd0);
        check("reset_acc_carry", {23'd0, bus.carry, bus.acc}, 32'd0);
        check("reset_alu_ports", {14'd0, bus.alu_op, bus.alu_flagen, bus.alu_a, bus.alu_b}, 32'd0);
        rst_n = 1'b1;

        prev_acc = 8'h00;
        for (int i = 0; i < 11; i++) begin
            run_cmd(vecs[i].cmd, vecs[i].flag, vecs[i].op, prev_acc, g_acc, g_carry, g_lat, g_busy, g_ok);
            check($sformatf("v%0d_acc", i), {24'd0, g_acc}, {24'd0, vecs[i].exp_acc});
            check($sformatf("v%0d_carry", i), {31'd0, g_carry}, {31'd0, vecs[i].exp_carry});
            check($sformatf("v%0d_busy_cycles", i), g_busy, vecs[i].exp_busy);
            check($sformatf("v%0d_latency", i), g_lat, vecs[i].exp_busy + 1);
            if (vecs[i].exp_busy != 0)
                check($sformatf("v%0d_alu_ports", i), {31'd0, g_ok}, 32'd1);
            prev_acc = vecs[i].exp_acc;
        end

        // Start pulsed with LOAD 0xAA during an ADD's settle window must be dropped.
        run_cmd(2'b10, 1'b0, 8'h11, prev_acc, g_acc, g_carry, g_lat, g_busy, g_ok);
        check("ign_preload", {24'd0, g_acc}, 32'h11);
        @(negedge clk);
        bus.start = 1'b1; bus.cmd = 2'b00; bus.flag_en = 1'b1; bus.operand = 8'h22;
        @(posedge clk);
        #1 bus.start = 1'b0;
        dones = 0;
        stable_ok = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (n == 2) begin bus.start = 1'b1; bus.cmd = 2'b10; bus.operand = 8'hAA; end
            if (n == 3) bus.start = 1'b0;
            if (bus.done) dones++;
            if (bus.busy && (bus.alu_a !== 8'h11 || bus.alu_b !== 8'h22)) stable_ok = 1'b0;
        end
        check("ign_done_count", dones, 1);
        check("ign_acc", {24'd0, bus.acc}, 32'h33);
        check("ign_carry", {31'd0, bus.carry}, 32'd0);
        check("ign_alu_stable", {31'd0, stable_ok}, 32'd1);

        // Start held high: LOAD 0x01, then ADD 0x01 accepted straight out of DONE.
        @(negedge clk);
        bus.start = 1'b1; bus.cmd = 2'b10; bus.flag_en = 1'b1; bus.operand = 8'h01;
        @(negedge clk);
        check("b2b_load_done", {31'd0, bus.done}, 32'd1);
        bus.cmd = 2'b00; bus.operand = 8'h01;
        @(negedge clk);
        bus.start = 1'b0;
        check("b2b_add_busy", {31'd0, bus.busy}, 32'd1);
        dones = 0;
        for (int n = 1; n <= 10 && dones == 0; n++) begin
            @(negedge clk);
            if (bus.done) begin
                dones++;
                check("b2b_add_latency", n, SETTLE);
            end
        end
        check("b2b_add_done_seen", dones, 1);
        check("b2b_acc", {24'd0, bus.acc}, 32'h02);

        // Reset two cycles into a SUB's settle window.
        run_cmd(2'b10, 1'b0, 8'h40, 8'h00, g_acc, g_carry, g_lat, g_busy, g_ok);
        @(negedge clk);
        bus.start = 1'b1; bus.cmd = 2'b01; bus.flag_en = 1'b1; bus.operand = 8'h05;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_busy_before", {31'd0, bus.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_mid_acc_carry", {23'd0, bus.carry, bus.acc}, 32'd0);
        check("rst_mid_alu_ports", {14'd0, bus.alu_op, bus.alu_flagen, bus.alu_a, bus.alu_b}, 32'd0);
        dones = 0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        rst_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("rst_mid_no_done", dones, 0);
        run_cmd(2'b10, 1'b0, 8'h22, 8'h00, g_acc, g_carry, g_lat, g_busy, g_ok);
        check("rst_after_load_acc", {24'd0, g_acc}, 32'h22);
        check("rst_after_load_lat", g_lat, 1);
        check("rst_after_carry", {31'd0, g_carry}, 32'd0);

        check("busy_done_overlap", overlap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/alu_driver.md
Name: alu_driver

Overview:
Sequencer on the driving side of the 8-bit add/sub ALU. It accepts one command at a time from the control unit and holds the ALU operands, op and flag-enable stable for a programmable settle window. It then captures the 9-bit ALU result into an 8-bit accumulator and a carry/borrow flag, and signals completion. It sits between the control unit and the ALU, and owns the accumulator (A-side operand) and the carry register.

Parameters:
SETTLE_CYCLES, 3, clock edges the ALU inputs are held stable before the result is captured; legal range 1..15; 0 is illegal.
CNT_W, 4, width of the settle counter; must hold SETTLE_CYCLES.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  command request, sampled on rising edge
cmd  input  2  00 ADD, 01 SUB, 10 LOAD, 11 CLR_C
flag_en  input  1  ADD/SUB only: 1 = update carry from result bit 8
operand  input  8  B operand (ADD/SUB) or load value (LOAD)
busy  output  1  high while an ADD/SUB is settling
done  output  1  one-cycle pulse: command complete, acc/carry valid
acc  output  8  accumulator
carry  output  1  carry (ADD) / borrow (SUB) flag
alu_op  output  1  to ALU op: 0 add, 1 subtract
alu_a  output  8  to ALU A (accumulator snapshot)
alu_b  output  8  to ALU B (latched operand)
alu_flagen  output  1  to ALU FLAGENABLE
alu_res  input  9  from ALU result; bit 8 = carry/borrow

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, counter 0. busy, done, acc, carry, alu_op, alu_a, alu_b and alu_flagen all 0. Reset takes priority at any point. An in-flight command is dropped, with no capture and no done.
- States: IDLE, SETTLE, DONE.
- IDLE or DONE with start=1 at edge E0 (commands are accepted back-to-back from DONE):
  - ADD/SUB:
    - Latch alu_a<=acc, alu_b<=operand, alu_op<=cmd[0], alu_flagen<=flag_en.
    - Counter<=SETTLE_CYCLES. Go to SETTLE. busy=1.
  - LOAD: acc<=operand. carry unchanged. ALU ports unchanged. Go to DONE (done high the cycle after E0).
  - CLR_C: carry<=0. acc unchanged. ALU ports unchanged. Go to DONE.
- SETTLE:
  - Counter decrements each edge. ALU ports are held constant.
  - start is ignored, with no queueing.
  - On the edge where the counter equals 1 (edge E0+SETTLE_CYCLES):
    - acc<=alu_res[7:0].
    - If the latched flag_en=1, carry<=alu_res[8]; otherwise carry is unchanged.
    - busy<=0. Go to DONE.
- DONE: done=1 for exactly one cycle. Next edge goes to IDLE, or accepts a new start as above.
- Latency:
  - ADD/SUB: done is high in the cycle following edge E0+SETTLE_CYCLES.
  - LOAD/CLR_C: done is high in the cycle following E0.
- Arithmetic is performed by the ALU. The driver only samples the result.
  - ADD: res[8] = carry-out.
  - SUB: res[8] = borrow (1 when A<B unsigned). acc takes the low 8 bits, wrapping modulo 256.
- ALU outputs keep their last values in IDLE/DONE (no return to zero), so the ALU sees no spurious transitions.
- busy and done are never high in the same cycle.
- A start held high continuously in IDLE/DONE issues one command per acceptance, re-sampled each time the block is in IDLE/DONE.
- Undefined cmd encodings: none; all 4 are defined.

Test Plan:
- Reset mid-SUB (assert rst_n=0 two cycles into SETTLE) -> acc=0, carry=0, busy=0, done never pulses; the next LOAD 0x22 succeeds with done one cycle later.
- LOAD 0x10; ADD 0x05, flag_en=1, SETTLE_CYCLES=3 -> busy high 3 cycles; done in the cycle after the 3rd edge following acceptance; acc=0x15, carry=0.
- LOAD 0xF0; ADD 0x20, flag_en=1 -> acc=0x10, carry=1. Repeat ADD 0x20 with flag_en=0 -> acc=0x30, carry stays 1.
- LOAD 0x03; SUB 0x05, flag_en=1 -> alu_op=1 during SETTLE; acc=0xFE, carry=1. Then CLR_C -> carry=0, acc=0xFE.
- ADD in flight with start pulsed (cmd=LOAD 0xAA) during SETTLE -> ignored; acc = ADD result; alu_a/alu_b constant through SETTLE; no extra done.
- Back-to-back: start held high with LOAD 0x01 then ADD 0x01 presented in DONE -> second command accepted from DONE with no IDLE gap; final acc=0x02.
